qupls_group_queue: RTL and testbench
====================================

Name: qupls_group_queue

Overview:
Decoupling FIFO of 4-wide instruction groups. Sits directly downstream of the branch-spacing stage and upstream of decode/rename.
- Absorbs bursts of split groups so fetch and extraction do not have to stall cycle-for-cycle with rename.
- Discards pure-padding groups, where all four slots are NOPs.
- Flushes on a branch miss.

Parameters:
DEPTH, 8, number of group entries; must be a power of 2, minimum 4
AFULL, 2, stall asserts when free entries <= AFULL

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  branch-miss flush; discard all queued groups
wr  in  1  ins_i holds a valid group this cycle
ins_i  in  4 x $bits(pipeline_reg_t)  incoming group, slot 0 oldest
full  out  1  queue full; a write this cycle is ignored
stall  out  1  almost-full back-pressure to the upstream stage
rd  in  1  downstream consumes ins_o this cycle
ins_o  out  4 x $bits(pipeline_reg_t)  group at head of queue
ins_v  out  1  ins_o is valid
count  out  $clog2(DEPTH)+1  occupied entries
drop_cnt  out  32  padding groups discarded (optional feature)
full_cnt  out  32  cycles with wr & full (optional feature)

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on posedge clk.
  - rst is synchronous and active-high. It clears rd_ptr, wr_ptr and count to 0, and sets full=0, stall=0, ins_v=0 and drop_cnt=full_cnt=0.
  - Reset mid-operation discards all contents, with no partial output.
- Storage and pointers:
  - DEPTH entries, each a 4-slot pipeline_reg_t group.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is tracked separately so full (count==DEPTH) and empty (count==0) are unambiguous.
- Padding detection: pad = ins_i[0..3].decbus.nop all set.
- Write accept: acc = wr & ~full & ~flush.
  - If acc & ~pad: store ins_i at wr_ptr, then wr_ptr+1 and count+1.
  - If acc & pad: nothing stored, no pointer change, drop_cnt+1.
- Read:
  - ins_v = (count!=0), combinational from registered count.
  - ins_o = entry[rd_ptr] when ins_v (first-word fall-through). Otherwise ins_o is the NOP group:
    - each slot: v=1, decbus.nop=1, decbus.alu=1, decbus.Rtz=1, ins=OP_NOP, len=8, mcip=12'h1A0, exc=FLT_NONE, pc=RSTPC;
    - all architectural register fields 0.
  - rd & ins_v: rd_ptr+1, count-1.
  - rd while empty is ignored; count never underflows.
- Simultaneous events:
  - Write and read in one cycle: count unchanged and both pointers advance.
  - Full plus rd plus wr: the write is ignored, because full is registered state. Count drops by 1.
  - Empty plus wr: no bypass. The group appears on ins_o the next cycle (1-cycle minimum latency).
  - flush has highest priority: pointers and count go to 0, and the same-cycle wr and rd are ignored. ins_v=0 next cycle.
- Status outputs:
  - full = (count==DEPTH).
  - stall = (DEPTH-count) <= AFULL.
  - Both are combinational from the count register, with no dependence on wr/rd in the same cycle.
- Ordering: groups leave in strict arrival order, and slot order within a group is preserved.

Optional Feature:
QUPLS_GQ_STATS_EN
- Defined: drop_cnt and full_cnt are 32-bit counters.
  - Both clear on rst; flush does not clear them.
  - Both saturate at 32'hFFFFFFFF, with no wrap.
  - drop_cnt increments per accepted padding group; full_cnt increments per cycle with wr & full.
- Undefined: both ports are tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset, then 3 non-padding groups written on consecutive cycles with rd=0 -> count=3, ins_v=1, ins_o = first group; stall=0.
- Write 6 groups with DEPTH=8, AFULL=2 -> stall=1 after the 6th. Write 8 -> full=1; a 9th write is ignored and, with STATS_EN, full_cnt=1. Then rd 8 times -> groups out in order, count=0, ins_v=0, ins_o=NOP group.
- Write a group with all four slots decbus.nop=1 -> count unchanged, drop_cnt=1. A following real group is the next output.
- Queue at count=4, wr & rd in the same cycle for 10 cycles -> count stays 4 and pointers wrap. Output sequence matches input order.
- count=5, flush with wr=1 and rd=1 in the same cycle -> next cycle count=0, ins_v=0. The written group is never output.
- Empty queue, wr=1 and rd=1 in the same cycle -> that cycle ins_v=0 and count stays 0. Next cycle ins_v=1 with the written group.

Source files
------------

// File: rtl/qupls_group_queue_pkg.sv
// Shared types for the group queue: one pipeline slot and its decode bus.
// Constants give the canonical NOP slot emitted while the queue is empty.
package qupls_group_queue_pkg;

    localparam logic [31:0] RSTPC  = 32'hFFFC_0100;
    localparam logic [31:0] OP_NOP = 32'h0000_00FF;

    typedef enum logic [7:0] {
        FLT_NONE  = 8'h00,
        FLT_UNIMP = 8'h37
    } cause_t;

    typedef struct packed {
        logic       nop;
        logic       alu;
        logic       Rtz;
        logic [5:0] Rd;
        logic [5:0] Rs1;
        logic [5:0] Rs2;
    } decbus_t;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [3:0]  len;
        logic [11:0] mcip;
        cause_t      exc;
        decbus_t     decbus;
    } pipeline_reg_t;

endpackage

// File: rtl/qupls_group_queue.sv
// FIFO of 4-wide instruction groups between branch spacing and rename.
// Define QUPLS_GQ_STATS_EN to build the drop/full statistics counters.
module qupls_group_queue
    import qupls_group_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AFULL = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wr,
    input  pipeline_reg_t [3:0]       ins_i,
    output logic                      full,
    output logic                      stall,
    input  logic                      rd,
    output pipeline_reg_t [3:0]       ins_o,
    output logic                      ins_v,
    output logic [$clog2(DEPTH):0]    count,
    output logic [31:0]               drop_cnt,
    output logic [31:0]               full_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pipeline_reg_t [3:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic                w_full;
    logic                w_empty;
    logic                w_pad;
    logic                w_acc;
    logic                w_we;
    logic                w_re;
    logic [CW-1:0]       w_free;
    pipeline_reg_t       w_nop_slot;
    pipeline_reg_t [3:0] w_nop_grp;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_free  = CW'(DEPTH) - r_count;

    assign w_pad = ins_i[0].decbus.nop & ins_i[1].decbus.nop
                 & ins_i[2].decbus.nop & ins_i[3].decbus.nop;

    assign w_acc = wr & ~w_full & ~flush;
    assign w_we  = w_acc & ~w_pad;
    assign w_re  = rd & ~w_empty & ~flush;

    always_comb begin
        w_nop_slot            = '0;
        w_nop_slot.v          = 1'b1;
        w_nop_slot.pc         = RSTPC;
        w_nop_slot.ins        = OP_NOP;
        w_nop_slot.len        = 4'd8;
        w_nop_slot.mcip       = 12'h1A0;
        w_nop_slot.exc        = FLT_NONE;
        w_nop_slot.decbus.nop = 1'b1;
        w_nop_slot.decbus.alu = 1'b1;
        w_nop_slot.decbus.Rtz = 1'b1;
    end

    assign w_nop_grp = {4{w_nop_slot}};

    // Entry storage needs no reset: ins_v masks stale contents.
    always_ff @(posedge clk) begin
        if (w_we && !rst)
            r_mem[r_wr_ptr] <= ins_i;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_we)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_re)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_we, w_re})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign full  = w_full;
    assign stall = (w_free <= CW'(AFULL));
    assign ins_v = ~w_empty;
    assign count = r_count;
    assign ins_o = ins_v ? r_mem[r_rd_ptr] : w_nop_grp;

`ifdef QUPLS_GQ_STATS_EN
    logic [31:0] r_drop_cnt;
    logic [31:0] r_full_cnt;

    // Both counters saturate rather than wrap; flush leaves them intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
            r_full_cnt <= '0;
        end else begin
            if (w_acc && w_pad && r_drop_cnt != 32'hFFFF_FFFF)
                r_drop_cnt <= r_drop_cnt + 32'd1;
            if (wr && w_full && r_full_cnt != 32'hFFFF_FFFF)
                r_full_cnt <= r_full_cnt + 32'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
    assign full_cnt = r_full_cnt;
`else
    assign drop_cnt = '0;
    assign full_cnt = '0;
`endif

endmodule

// File: tb/tb_qupls_group_queue.sv
// Directed bench for qupls_group_queue with a scoreboard of expected groups.
// Stats expectations follow QUPLS_GQ_STATS_EN when it is defined.
module tb_qupls_group_queue;
    import qupls_group_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int AFULL = 2;

    typedef pipeline_reg_t [3:0] grp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        wr;
    logic        rd;
    grp_t        ins_i;
    grp_t        ins_o;
    logic        full;
    logic        stall;
    logic        ins_v;
    logic [3:0]  count;
    logic [31:0] drop_cnt;
    logic [31:0] full_cnt;

    int   nvec = 0;
    int   nerr = 0;
    grp_t sb[$];
    int   m_drop = 0;
    int   m_full = 0;
    grp_t nop_grp;

    always #5 clk = ~clk;

    qupls_group_queue #(.DEPTH(DEPTH), .AFULL(AFULL)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr(wr), .ins_i(ins_i),
        .full(full), .stall(stall), .rd(rd), .ins_o(ins_o), .ins_v(ins_v),
        .count(count), .drop_cnt(drop_cnt), .full_cnt(full_cnt)
    );

    function automatic grp_t mkgrp(input int id, input bit pad);
        grp_t g;
        g = '0;
        for (int s = 0; s < 4; s++) begin
            g[s].v          = 1'b1;
            g[s].pc         = RSTPC + 32'(id * 32 + s * 8);
            g[s].ins        = {id[15:0], 16'(s)};
            g[s].len        = 4'd8;
            g[s].exc        = FLT_NONE;
            g[s].decbus.nop = pad;
            g[s].decbus.Rd  = 6'(id + s);
            g[s].decbus.Rs1 = 6'(s + 1);
        end
        return g;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkg(input string tag, input grp_t obs, input grp_t exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef QUPLS_GQ_STATS_EN
        chk({tag, "_drop"}, 64'(drop_cnt), 64'(m_drop));
        chk({tag, "_fullc"}, 64'(full_cnt), 64'(m_full));
`else
        chk({tag, "_drop"}, 64'(drop_cnt), 64'd0);
        chk({tag, "_fullc"}, 64'(full_cnt), 64'd0);
`endif
    endtask

    // One clock: check registered outputs, update model, then advance.
    task automatic cyc(input bit r, input bit f, input bit w, input bit d,
                       input grp_t g);
        int mc;
        bit mfull;
        rst   = r;
        flush = f;
        wr    = w;
        rd    = d;
        ins_i = g;
        mc    = sb.size();
        mfull = (mc == DEPTH);
        chk("ins_v", 64'(ins_v), 64'(mc != 0));
        chk("count", 64'(count), 64'(mc));
        chk("full", 64'(full), 64'(mfull));
        chk("stall", 64'(stall), 64'((DEPTH - mc) <= AFULL));
        if (mc != 0)
            chkg("ins_o", ins_o, sb[0]);
        else
            chkg("ins_o_nop", ins_o, nop_grp);
        if (r) begin
            sb.delete();
            m_drop = 0;
            m_full = 0;
        end else if (f) begin
            sb.delete();
        end else begin
            if (w && mfull)
                m_full++;
            if (d && mc != 0)
                void'(sb.pop_front());
            if (w && !mfull) begin
                if (&{g[0].decbus.nop, g[1].decbus.nop,
                      g[2].decbus.nop, g[3].decbus.nop})
                    m_drop++;
                else
                    sb.push_back(g);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, '0);
    endtask

    initial begin
        for (int s = 0; s < 4; s++) begin
            nop_grp[s]            = '0;
            nop_grp[s].v          = 1'b1;
            nop_grp[s].pc         = RSTPC;
            nop_grp[s].ins        = OP_NOP;
            nop_grp[s].len        = 4'd8;
            nop_grp[s].mcip       = 12'h1A0;
            nop_grp[s].exc        = FLT_NONE;
            nop_grp[s].decbus.nop = 1'b1;
            nop_grp[s].decbus.alu = 1'b1;
            nop_grp[s].decbus.Rtz = 1'b1;
        end
        rst = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; ins_i = '0;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, '0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ins_v", 64'(ins_v), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk_stats("rst");

        for (int i = 1; i <= 3; i++)
            cyc(0, 0, 1, 0, mkgrp(i, 0));
        chk("t1_count", 64'(count), 64'd3);
        chk("t1_stall", 64'(stall), 64'd0);
        chkg("t1_head", ins_o, mkgrp(1, 0));
        while (sb.size() != 0)
            cyc(0, 0, 0, 1, '0);

        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 0, mkgrp(10 + i, 0));
            if (i == 4)
                chk("t2_stall5", 64'(stall), 64'd0);
            if (i == 5)
                chk("t2_stall6", 64'(stall), 64'd1);
        end
        chk("t2_full", 64'(full), 64'd1);
        cyc(0, 0, 1, 0, mkgrp(18, 0));
        chk("t2_count9", 64'(count), 64'd8);
        chk_stats("t2");
        for (int i = 0; i < 8; i++)
            cyc(0, 0, 0, 1, '0);
        chk("t2_empty", 64'(ins_v), 64'd0);
        chkg("t2_nop", ins_o, nop_grp);

        cyc(0, 0, 1, 0, mkgrp(19, 1));
        chk("t3_count", 64'(count), 64'd0);
        chk_stats("t3");
        cyc(0, 0, 1, 0, mkgrp(20, 0));
        chkg("t3_next", ins_o, mkgrp(20, 0));
        cyc(0, 0, 0, 1, '0);

        for (int i = 0; i < 4; i++)
            cyc(0, 0, 1, 0, mkgrp(30 + i, 0));
        for (int i = 0; i < 10; i++)
            cyc(0, 0, 1, 1, mkgrp(40 + i, 0));
        chk("t4_count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 0, 1, '0);

        for (int i = 0; i < 5; i++)
            cyc(0, 0, 1, 0, mkgrp(50 + i, 0));
        cyc(0, 1, 1, 1, mkgrp(59, 0));
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_ins_v", 64'(ins_v), 64'd0);
        idle();

        rst = 1'b0; flush = 1'b0; wr = 1'b1; rd = 1'b1;
        ins_i = mkgrp(60, 0);
        #1;
        chk("t6_v_same", 64'(ins_v), 64'd0);
        cyc(0, 0, 1, 1, mkgrp(60, 0));
        chk("t6_v_next", 64'(ins_v), 64'd1);
        chkg("t6_out", ins_o, mkgrp(60, 0));
        cyc(0, 0, 0, 1, '0);

        cyc(0, 0, 1, 0, mkgrp(70, 0));
        cyc(0, 0, 1, 0, mkgrp(71, 1));
        cyc(1, 0, 1, 1, mkgrp(72, 0));
        chk("t7_count", 64'(count), 64'd0);
        chk("t7_ins_v", 64'(ins_v), 64'd0);
        chk_stats("t7");
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
